// File: rtl/viterbi_tb_ctrl.sv
// Viterbi traceback controller: sequences survivor writes, walks the memory backwards, and streams out the decoded bits.
// Optional VITERBI_TB_BEST_STATE_EN: start traceback from i_best_state instead of the zero-tail state 0.
module viterbi_tb_ctrl #(
  parameter int K        = 3,
  parameter int TB_DEPTH = 16,
  parameter int AW       = $clog2(TB_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                i_en_td,
  input  logic                i_en_t,
  input  logic                i_dec_valid,
  input  logic [K-2:0]        i_best_state,
  output logic                o_mem_wen,
  output logic [AW-1:0]       o_mem_waddr,
  output logic                o_mem_ren,
  output logic [AW-1:0]       o_mem_raddr,
  input  logic [(1<<(K-1))-1:0] i_mem_rdata,
  output logic                o_td_full,
  output logic                o_bit,
  output logic                o_bit_valid,
  input  logic                i_bit_ready,
  output logic                o_done
);

  localparam int SW = K - 1;
  localparam int LD = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(TB_DEPTH);
  localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    TB_RD,
    TB_STEP,
    OUT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [AW:0]   wcnt;
  logic [AW:0]   rptr;
  logic [AW:0]   lcnt;
  logic [SW-1:0] tb_state;
  logic [SW-1:0] start_state;
  logic [LD-1:0] lifo;
  logic [AW-1:0] rd_idx;
  logic          full;
  logic          tb_req;
  logic          tb_start;
  logic          wr_fire;
  logic          step_fire;
  logic          accept;
  logic          d_bit;

`ifdef VITERBI_TB_BEST_STATE_EN
  assign start_state = i_best_state;
`else
  logic unused_best_state;
  assign unused_best_state = ^i_best_state;
  assign start_state       = '0;
`endif

  assign full      = (wcnt == DEPTH_CNT);
  assign tb_req    = en && i_en_t && ((state == IDLE) || (state == WRITE));
  assign tb_start  = tb_req && (wcnt != '0);
  assign wr_fire   = en && (state == WRITE) && i_dec_valid && !full && !i_en_t;
  assign step_fire = en && (state == TB_STEP);
  assign accept    = en && (state == OUT) && i_bit_ready;
  assign d_bit     = i_mem_rdata[tb_state];
  // The LIFO top sits one below lcnt; the low AW bits are enough because lcnt never exceeds TB_DEPTH.
  assign rd_idx    = lcnt[AW-1:0] - AW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (en) begin
      case (state)
        IDLE: begin
          if (i_en_t)       state_next = (wcnt == '0) ? DONE : TB_RD;
          else if (i_en_td) state_next = WRITE;
        end
        WRITE: begin
          if (i_en_t) state_next = (wcnt == '0) ? DONE : TB_RD;
        end
        TB_RD:   state_next = TB_STEP;
        TB_STEP: state_next = (rptr == '0) ? OUT : TB_RD;
        OUT: begin
          if (i_bit_ready && (lcnt == ONE_CNT)) state_next = DONE;
        end
        DONE: begin
          if (!i_en_t) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Write counter: there is no wrap-around, so it only clears once the frame has been fully consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt <= '0;
    end else if (wr_fire) begin
      wcnt <= wcnt + ONE_CNT;
    end else if (en && (state == DONE) && !i_en_t) begin
      wcnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr <= '0;
    end else if (tb_start) begin
      rptr <= wcnt - ONE_CNT;
    end else if (step_fire && (rptr != '0)) begin
      rptr <= rptr - ONE_CNT;
    end
  end

  // Walking backwards undoes next_state = {u, state[SW-1:1]}: the survivor bit refills the LSB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tb_state <= '0;
    end else if (tb_start) begin
      tb_state <= start_state;
    end else if (step_fire) begin
      tb_state <= {tb_state[SW-2:0], d_bit};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcnt <= '0;
    end else if (tb_req) begin
      lcnt <= '0;
    end else if (step_fire) begin
      lcnt <= lcnt + ONE_CNT;
    end else if (accept) begin
      lcnt <= lcnt - ONE_CNT;
    end
  end

  // LIFO storage needs no reset; only lcnt decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (step_fire) lifo[lcnt[AW-1:0]] <= tb_state[SW-1];
  end

  always_comb begin
    o_mem_wen   = wr_fire;
    o_mem_waddr = wr_fire ? wcnt[AW-1:0] : '0;
    o_mem_ren   = en && (state == TB_RD);
    o_mem_raddr = (en && (state == TB_RD)) ? rptr[AW-1:0] : '0;
    o_td_full   = full;
    o_bit_valid = (state == OUT);
    o_bit       = (state == OUT) ? lifo[rd_idx] : 1'b0;
    o_done      = (state == DONE);
  end

endmodule

// File: tb/tb_viterbi_tb_ctrl.sv
// Directed bench for viterbi_tb_ctrl (K=3, TB_DEPTH=16) with a simple synchronous memory model.
module tb_viterbi_tb_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       i_en_td = 1'b0;
  logic       i_en_t = 1'b0;
  logic       i_dec_valid = 1'b0;
  logic [1:0] i_best_state = 2'b00;
  logic       o_mem_wen;
  logic [3:0] o_mem_waddr;
  logic       o_mem_ren;
  logic [3:0] o_mem_raddr;
  logic [3:0] i_mem_rdata = 4'h0;
  logic       o_td_full;
  logic       o_bit;
  logic       o_bit_valid;
  logic       i_bit_ready = 1'b1;
  logic       o_done;

  int checks = 0;
  int failures = 0;

  logic [3:0] mem [16];
  logic [3:0] dec_data = 4'h0;
  logic [3:0] frame [16];

  int rd_q[$];
  int bit_q[$];
  int first_valid;
  int done_idx;
  int last_idx;
  int stall_bad;
  int freeze_bad;
  bit timed_out;

  viterbi_tb_ctrl #(.K(3), .TB_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .i_en_td(i_en_td), .i_en_t(i_en_t),
    .i_dec_valid(i_dec_valid), .i_best_state(i_best_state),
    .o_mem_wen(o_mem_wen), .o_mem_waddr(o_mem_waddr),
    .o_mem_ren(o_mem_ren), .o_mem_raddr(o_mem_raddr), .i_mem_rdata(i_mem_rdata),
    .o_td_full(o_td_full), .o_bit(o_bit), .o_bit_valid(o_bit_valid),
    .i_bit_ready(i_bit_ready), .o_done(o_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_mem_wen) mem[o_mem_waddr] <= dec_data;
    if (o_mem_ren) i_mem_rdata <= mem[o_mem_raddr];
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b1; i_en_td = 1'b0; i_en_t = 1'b0;
    i_dec_valid = 1'b0; i_bit_ready = 1'b1; dec_data = 4'h0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load_frame(input int n);
    @(negedge clk);
    i_en_td = 1'b1; i_dec_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i_dec_valid = 1'b1; dec_data = frame[k];
    end
    @(negedge clk);
    i_dec_valid = 1'b0;
  endtask

  // Raises i_en_t and records read addresses, accepted bits and timing; index c counts cycles since TB_RD entry.
  task automatic run_traceback(input bit freeze, input int stall_at);
    int   stall_cnt;
    logic held_bit;
    stall_cnt = 0; held_bit = 1'b0;
    rd_q.delete(); bit_q.delete();
    first_valid = -1; done_idx = -1; last_idx = -1;
    stall_bad = 0; freeze_bad = 0; timed_out = 1'b1;
    @(negedge clk);
    i_en_t = 1'b1; i_en_td = 1'b0; i_bit_ready = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      en = !(freeze && (c >= 3) && (c <= 6));
      #1;
      if (!en && (o_mem_ren || o_mem_wen)) freeze_bad++;
      if (o_mem_ren) rd_q.push_back(int'(o_mem_raddr));
      if (o_done) begin
        done_idx = c; timed_out = 1'b0;
        break;
      end
      if (stall_cnt > 0 && stall_cnt < 3 && !o_bit_valid) stall_bad++;
      if (o_bit_valid) begin
        if (first_valid < 0) first_valid = c;
        if (bit_q.size() == stall_at && stall_cnt < 3) begin
          if (stall_cnt == 0) held_bit = o_bit;
          else if (o_bit !== held_bit) stall_bad++;
          stall_cnt++;
          i_bit_ready = 1'b0;
        end else begin
          i_bit_ready = 1'b1;
          bit_q.push_back(int'(o_bit));
          last_idx = c;
        end
      end
    end
    en = 1'b1; i_bit_ready = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({o_mem_wen, o_mem_waddr, o_mem_ren, o_mem_raddr, o_td_full, o_bit, o_bit_valid, o_done} !== 14'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {o_mem_wen, o_mem_waddr, o_mem_ren, o_mem_raddr, o_td_full, o_bit, o_bit_valid, o_done});
    end
    @(negedge clk);
    rst = 1'b1; i_en_td = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      i_dec_valid = 1'b1; dec_data = 4'(k);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({o_mem_wen, o_mem_waddr, o_mem_ren, o_mem_raddr, o_td_full, o_bit, o_bit_valid, o_done} !== 14'h0) begin
      failures++;
      $display("[TB] FAIL midwrite_reset: got %h expected 0", {o_mem_wen, o_mem_waddr, o_mem_ren, o_mem_raddr, o_td_full, o_bit, o_bit_valid, o_done});
    end
    @(negedge clk);
    rst = 1'b1; i_dec_valid = 1'b0;
    @(negedge clk);
    i_dec_valid = 1'b1;
    #1;
    checks++;
    if (o_mem_wen !== 1'b1 || o_mem_waddr !== 4'd0) begin
      failures++;
      $display("[TB] FAIL post_reset_waddr: got wen=%b waddr=%0d expected wen=1 waddr=0", o_mem_wen, o_mem_waddr);
    end
    @(negedge clk);
    i_dec_valid = 1'b0;
  endtask

  task automatic test_fill();
    do_reset();
    @(negedge clk);
    i_en_td = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      i_dec_valid = 1'b1; dec_data = 4'(k);
      #1;
      checks++;
      if (k < 16) begin
        if (o_mem_wen !== 1'b1 || o_mem_waddr !== 4'(k)) begin
          failures++;
          $display("[TB] FAIL fill_write%0d: got wen=%b waddr=%0d expected wen=1 waddr=%0d", k, o_mem_wen, o_mem_waddr, k);
        end
      end else if (o_mem_wen !== 1'b0 || o_mem_waddr !== 4'd0) begin
        failures++;
        $display("[TB] FAIL fill_drop17: got wen=%b waddr=%0d expected wen=0 waddr=0", o_mem_wen, o_mem_waddr);
      end
      if (k == 15 || k == 16) begin
        checks++;
        if (o_td_full !== (k == 16)) begin
          failures++;
          $display("[TB] FAIL fill_full%0d: got %b expected %b", k, o_td_full, (k == 16));
        end
      end
    end
    @(negedge clk);
    i_dec_valid = 1'b0;
  endtask

  task automatic test_zero_tail();
    int exp_bits[6] = '{1, 0, 1, 1, 0, 0};
    do_reset();
    frame[0] = 4'b0100; frame[1] = 4'b0010; frame[2] = 4'b0100;
    frame[3] = 4'b0000; frame[4] = 4'b0010; frame[5] = 4'b0001;
    i_best_state = 2'b00;
    load_frame(6);
    run_traceback(1'b0, -1);
    checks++;
    if (timed_out || rd_q.size() != 6 || bit_q.size() != 6) begin
      failures++;
      $display("[TB] FAIL zt_counts: got timeout=%0d reads=%0d bits=%0d expected 0/6/6", timed_out, rd_q.size(), bit_q.size());
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= rd_q.size() || rd_q[k] != 5 - k) begin
        failures++;
        $display("[TB] FAIL zt_raddr%0d: got %0d expected %0d", k, (k < rd_q.size()) ? rd_q[k] : -1, 5 - k);
      end
      checks++;
      if (k >= bit_q.size() || bit_q[k] != exp_bits[k]) begin
        failures++;
        $display("[TB] FAIL zt_bit%0d: got %0d expected %0d", k, (k < bit_q.size()) ? bit_q[k] : -1, exp_bits[k]);
      end
    end
    checks++;
    if (first_valid != 12) begin
      failures++;
      $display("[TB] FAIL zt_latency: got %0d expected 12", first_valid);
    end
    checks++;
    if (done_idx != last_idx + 1) begin
      failures++;
      $display("[TB] FAIL zt_done: got cycle %0d expected %0d", done_idx, last_idx + 1);
    end
    i_en_t = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (o_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zt_done_clear: got %b expected 0", o_done);
    end
    i_en_td = 1'b1;
    @(negedge clk);
    i_dec_valid = 1'b1; dec_data = 4'h0;
    #1;
    checks++;
    if (o_mem_wen !== 1'b1 || o_mem_waddr !== 4'd0) begin
      failures++;
      $display("[TB] FAIL back_to_back_waddr: got wen=%b waddr=%0d expected wen=1 waddr=0", o_mem_wen, o_mem_waddr);
    end
    @(negedge clk);
    i_dec_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int exp_bits[6] = '{1, 0, 1, 1, 0, 0};
    do_reset();
    i_best_state = 2'b00;
    load_frame(6);
    run_traceback(1'b0, 2);
    checks++;
    if (timed_out || bit_q.size() != 6 || stall_bad != 0) begin
      failures++;
      $display("[TB] FAIL bp_stream: got timeout=%0d bits=%0d stall_errors=%0d expected 0/6/0", timed_out, bit_q.size(), stall_bad);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= bit_q.size() || bit_q[k] != exp_bits[k]) begin
        failures++;
        $display("[TB] FAIL bp_bit%0d: got %0d expected %0d", k, (k < bit_q.size()) ? bit_q[k] : -1, exp_bits[k]);
      end
    end
    checks++;
    if (done_idx != last_idx + 1) begin
      failures++;
      $display("[TB] FAIL bp_done: got cycle %0d expected %0d", done_idx, last_idx + 1);
    end
    i_en_t = 1'b0;
  endtask

  task automatic test_en_freeze();
    int exp_bits[6] = '{1, 0, 1, 1, 0, 0};
    do_reset();
    i_best_state = 2'b00;
    load_frame(6);
    run_traceback(1'b1, -1);
    checks++;
    if (timed_out || freeze_bad != 0 || rd_q.size() != 6) begin
      failures++;
      $display("[TB] FAIL freeze_mem: got timeout=%0d strobes=%0d reads=%0d expected 0/0/6", timed_out, freeze_bad, rd_q.size());
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= rd_q.size() || rd_q[k] != 5 - k || k >= bit_q.size() || bit_q[k] != exp_bits[k]) begin
        failures++;
        $display("[TB] FAIL freeze_entry%0d: got raddr=%0d bit=%0d expected raddr=%0d bit=%0d", k,
                 (k < rd_q.size()) ? rd_q[k] : -1, (k < bit_q.size()) ? bit_q[k] : -1, 5 - k, exp_bits[k]);
      end
    end
    checks++;
    if (first_valid != 16) begin
      failures++;
      $display("[TB] FAIL freeze_latency: got %0d expected 16", first_valid);
    end
    i_en_t = 1'b0;
  endtask

  task automatic test_best_state();
`ifdef VITERBI_TB_BEST_STATE_EN
    int n = 4;
    int exp_bits[6] = '{1, 0, 1, 1, 0, 0};
`else
    int n = 6;
    int exp_bits[6] = '{1, 0, 1, 1, 0, 0};
`endif
    do_reset();
    i_best_state = 2'b11;
    load_frame(n);
    run_traceback(1'b0, -1);
    checks++;
    if (timed_out || bit_q.size() != n || first_valid != 2 * n) begin
      failures++;
      $display("[TB] FAIL best_counts: got timeout=%0d bits=%0d latency=%0d expected 0/%0d/%0d", timed_out, bit_q.size(), first_valid, n, 2 * n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (k >= bit_q.size() || bit_q[k] != exp_bits[k]) begin
        failures++;
        $display("[TB] FAIL best_bit%0d: got %0d expected %0d", k, (k < bit_q.size()) ? bit_q[k] : -1, exp_bits[k]);
      end
    end
    i_en_t = 1'b0;
    i_best_state = 2'b00;
  endtask

  task automatic test_empty_traceback();
    do_reset();
    @(negedge clk);
    i_en_t = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (o_done !== 1'b1 || o_mem_ren !== 1'b0) begin
      failures++;
      $display("[TB] FAIL empty_done: got done=%b ren=%b expected done=1 ren=0", o_done, o_mem_ren);
    end
    i_en_t = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (o_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL empty_release: got %b expected 0", o_done);
    end
  endtask

  initial begin
    $display("[TB] viterbi_tb_ctrl directed bench");
    test_reset();
    test_fill();
    test_zero_tail();
    test_backpressure();
    test_en_freeze();
    test_best_state();
    test_empty_traceback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
